// File: rtl/fetch_byte_aligner_pkg.sv
// Shared constants for the fetch byte aligner and its window rotator.
// Widths here size the fetch line, circular buffer and decode length port.
package fetch_byte_aligner_pkg;
    localparam int FETCH_LINE_BYTES = 16;
    localparam int ALIGN_BUF_BYTES  = 32;
    localparam int MAX_INSN_BYTES   = 15;
    localparam int LEN_W            = 5;
endpackage

// File: rtl/fetch_byte_aligner_byte_window_rotator.sv
// Combinational 32-to-16 byte barrel selector starting at rd_ptr.
// Bytes at or beyond the valid count are forced to zero.
module byte_window_rotator
    import fetch_byte_aligner_pkg::*;
#(
    parameter int BUF_BYTES = ALIGN_BUF_BYTES,
    parameter int WIN_BYTES = FETCH_LINE_BYTES,
    parameter int PTR_W     = $clog2(BUF_BYTES)
) (
    input  logic [BUF_BYTES-1:0][7:0] buf_bytes,
    input  logic [PTR_W-1:0]          rd_ptr,
    input  logic [5:0]                win_count,
    output logic [WIN_BYTES-1:0][7:0] win
);

    always_comb begin
        win = '0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            // index wraps naturally in PTR_W bits
            if (6'(k) < win_count) begin
                win[k] = buf_bytes[rd_ptr + PTR_W'(k)];
            end
        end
    end

endmodule

// File: rtl/fetch_byte_aligner.sv
// Byte queue between fetch and decode: accepts 16-byte lines and presents
// a window whose byte 0 is always the next unconsumed instruction byte.
module fetch_byte_aligner
    import fetch_byte_aligner_pkg::*;
#(
    parameter int LINE_BYTES = FETCH_LINE_BYTES,
    parameter int BUF_BYTES  = ALIGN_BUF_BYTES,
    parameter int WIN_BYTES  = FETCH_LINE_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    f_valid,
    output logic                    f_ready,
    input  logic [8*LINE_BYTES-1:0] f_data,
    output logic                    d_valid,
    output logic [5:0]              d_count,
    output logic [8*WIN_BYTES-1:0]  d_data,
    input  logic                    d_ready,
    input  logic [LEN_W-1:0]        d_len,
    output logic                    len_err
);

    localparam int PTR_W = $clog2(BUF_BYTES);

    logic [BUF_BYTES-1:0][7:0] buf_q, buf_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [5:0]                count_q, count_d;
    logic                      len_err_q, len_err_d;
    logic                      rst_done_q;
    logic [5:0]                win_count;
    logic [PTR_W-1:0]          wr_base;
    logic                      acc, take, legal, con, bad;
    logic [WIN_BYTES-1:0][7:0] win;

    assign win_count = (count_q > 6'(WIN_BYTES)) ? 6'(WIN_BYTES) : count_q;
    assign d_count   = win_count;
    assign d_valid   = (count_q != 6'd0);
    assign d_data    = win;
    assign len_err   = len_err_q;
    // room for one more line once at most half the buffer is occupied
    assign f_ready   = rst_done_q & (count_q <= 6'(BUF_BYTES - LINE_BYTES));

    assign acc   = f_valid & f_ready & ~flush;
    assign take  = d_valid & d_ready;
    assign legal = (d_len != '0) & ({1'b0, d_len} <= win_count);
    assign con   = take & legal;
    assign bad   = take & ~legal;

    assign wr_base = rd_ptr_q + count_q[PTR_W-1:0];

    always_comb begin
        buf_d     = buf_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        len_err_d = bad;
        if (acc) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                buf_d[wr_base + PTR_W'(k)] = f_data[8*k +: 8];
            end
            count_d = count_d + 6'(LINE_BYTES);
        end
        if (con) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(d_len);
            count_d  = count_d - {1'b0, d_len};
        end
        if (flush) begin
            rd_ptr_d  = '0;
            count_d   = '0;
            len_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            count_q    <= '0;
            len_err_q  <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            len_err_q  <= len_err_d;
            rst_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    byte_window_rotator #(
        .BUF_BYTES (BUF_BYTES),
        .WIN_BYTES (WIN_BYTES),
        .PTR_W     (PTR_W)
    ) u_rot (
        .buf_bytes (buf_q),
        .rd_ptr    (rd_ptr_q),
        .win_count (win_count),
        .win       (win)
    );

endmodule

// File: tb/tb_fetch_byte_aligner.sv
// Bench for fetch_byte_aligner: directed cases plus random traffic
// compared against a byte-queue reference model.
module tb_fetch_byte_aligner;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         f_valid = 1'b0;
    logic         d_ready = 1'b0;
    logic [127:0] f_data = '0;
    logic [4:0]   d_len = '0;
    logic         f_ready, d_valid, len_err;
    logic [5:0]   d_count;
    logic [127:0] d_data;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] mq[$];
    logic       m_err = 1'b0;
    logic       m_rdy = 1'b0;

    fetch_byte_aligner dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .f_data  (f_data),
        .d_valid (d_valid),
        .d_count (d_count),
        .d_data  (d_data),
        .d_ready (d_ready),
        .d_len   (d_len),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line(input logic [7:0] base);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = base + 8'(k);
        return l;
    endfunction

    task automatic check_all();
        logic [127:0] w;
        int n;
        n = mq.size();
        w = '0;
        for (int k = 0; k < 16; k++) if (k < n) w[8*k +: 8] = mq[k];
        chk("f_ready", f_ready, m_rdy && n <= 16);
        chk("d_valid", d_valid, n > 0);
        chk("d_count", d_count, (n > 16) ? 16 : n);
        chk("d_data", d_data, w);
        chk("len_err", len_err, m_err);
        chk("occupancy", (n >= 0 && n <= 32), 1'b1);
    endtask

    // Drive one cycle of inputs at negedge, advance the model at the
    // posedge, then compare every output at the following negedge.
    task automatic cycle(input logic fv, input logic [127:0] fd,
                         input logic dr, input logic [4:0] dl,
                         input logic fl);
        int n;
        bit acc, take, legal;
        logic [7:0] tmp;
        f_valid = fv;
        f_data  = fd;
        d_ready = dr;
        d_len   = dl;
        flush   = fl;
        n     = mq.size();
        acc   = fv && m_rdy && n <= 16 && !fl;
        take  = dr && n > 0;
        legal = dl >= 1 && int'(dl) <= ((n > 16) ? 16 : n);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            m_err = take && !legal;
            if (take && legal) repeat (int'(dl)) tmp = mq.pop_front();
            if (acc) for (int k = 0; k < 16; k++) mq.push_back(fd[8*k +: 8]);
        end
        m_rdy = 1'b1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dvalid", d_valid, 0);
        chk("rst_dcount", d_count, 0);
        chk("rst_ddata", d_data, 0);
        chk("rst_fready", f_ready, 0);
        chk("rst_lenerr", len_err, 0);
        reset = 1'b1;
        #1;
        chk("rel_fready_pre_edge", f_ready, 0);

        cycle(0, '0, 0, 0, 0);
        chk("t1_fready", f_ready, 1);
        cycle(1, line(8'h00), 0, 0, 0);
        chk("t1_dvalid", d_valid, 1);
        chk("t1_dcount", d_count, 16);
        chk("t1_b0", d_data[7:0], 8'h00);
        chk("t1_b15", d_data[127:120], 8'h0F);
        chk("t1_fready2", f_ready, 1);

        cycle(1, line(8'h10), 0, 0, 0);
        chk("t2_full", f_ready, 0);
        cycle(0, '0, 1, 3, 0);
        chk("t2_b0", d_data[7:0], 8'h03);
        chk("t2_fready29", f_ready, 0);
        cycle(0, '0, 1, 13, 0);
        chk("t2_rise", f_ready, 1);
        chk("t2_b0b", d_data[7:0], 8'h10);

        cycle(0, '0, 1, 12, 0);
        chk("t3_cnt4", d_count, 4);
        chk("t3_b0", d_data[7:0], 8'h1C);
        cycle(1, line(8'h20), 0, 0, 0);
        chk("t3_cnt", d_count, 16);
        chk("t3_b3", d_data[31:24], 8'h1F);
        chk("t3_b4", d_data[39:32], 8'h20);
        chk("t3_b15", d_data[127:120], 8'h2B);

        cycle(0, '0, 1, 4, 0);
        chk("t4_b0pre", d_data[7:0], 8'h20);
        cycle(1, line(8'h30), 1, 5, 0);
        chk("t4_b0", d_data[7:0], 8'h25);
        chk("t4_fready", f_ready, 0);

        cycle(0, '0, 0, 0, 1);
        cycle(1, line(8'h40), 0, 0, 0);
        cycle(0, '0, 1, 12, 0);
        cycle(0, '0, 1, 7, 0);
        chk("t5_err", len_err, 1);
        chk("t5_cnt", d_count, 4);
        chk("t5_b0", d_data[7:0], 8'h4C);
        cycle(0, '0, 0, 0, 0);
        chk("t5_err_clr", len_err, 0);
        cycle(0, '0, 1, 0, 0);
        chk("t5_err0", len_err, 1);
        chk("t5_cnt0", d_count, 4);

        cycle(1, line(8'h50), 0, 0, 0);
        cycle(1, line(8'h60), 0, 0, 1);
        chk("t6_dvalid", d_valid, 0);
        chk("t6_dcount", d_count, 0);
        chk("t6_fready", f_ready, 1);
        cycle(0, '0, 1, 3, 0);
        chk("t6_empty_noerr", len_err, 0);

        for (int i = 0; i < 3000; i++) begin
            logic fl, fv, dr;
            logic [4:0] dl;
            fl = ($urandom_range(0, 49) == 0);
            fv = ($urandom_range(0, 2) != 0);
            dr = 1'($urandom);
            dl = ($urandom_range(0, 19) == 0) ? 5'($urandom)
                                              : 5'($urandom_range(1, 16));
            cycle(fv, {$urandom, $urandom, $urandom, $urandom}, dr, dl, fl);
        end

        cycle(1, line(8'h70), 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_dvalid", d_valid, 0);
        chk("arst_dcount", d_count, 0);
        chk("arst_ddata", d_data, 0);
        chk("arst_fready", f_ready, 0);
        chk("arst_lenerr", len_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
